// File: rtl/mult_seq_radix4_pkg.sv
// Shared definitions for the sequential radix-4 multiplier: default operand width and FSM states.
package mult_seq_radix4_pkg;

  localparam int unsigned DATA_W_DEFAULT = 16;

  // Encoding 2'd3 is never entered; the FSM treats it as IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mult_pp_radix4.sv
// Radix-4 partial-product select: returns 0, A, 2A or 3A for a 2-bit multiplier digit.
module mult_pp_radix4 #(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [1:0]        sel,
  output logic [DATA_W+1:0] pp
);

  always_comb begin
    pp = '0;
    case (sel)
      2'd0: pp = '0;
      2'd1: pp = {2'b00, a};
      2'd2: pp = {1'b0, a, 1'b0};
      2'd3: pp = {1'b0, a, 1'b0} + {2'b00, a};
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/mult_seq_radix4.sv
// Iterative unsigned radix-4 multiplier, two multiplier bits per clock, start/busy/done handshake.
// Optional build macro MULT_SEQ_EARLY_EXIT_EN finishes as soon as the remaining multiplier is zero.
module mult_seq_radix4
  import mult_seq_radix4_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iStart,
  input  logic [DATA_W-1:0]     iDato_A,
  input  logic [DATA_W-1:0]     iDato_B,
  output logic                  oBusy,
  output logic                  oDone,
  output logic [2*DATA_W-1:0]   oResult
);

  localparam int unsigned RESULT_W = 2 * DATA_W;
  localparam int unsigned STEPS    = DATA_W / 2;
  localparam int unsigned CNT_W    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  state_e                state_q, state_d;
  logic [DATA_W-1:0]     a_q, a_d;
  logic [DATA_W-1:0]     rb_q, rb_d;
  logic [RESULT_W-1:0]   acc_q, acc_d;
  logic [RESULT_W-1:0]   result_q, result_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  done_q, done_d;

  logic [DATA_W+1:0]     pp;
  logic [RESULT_W-1:0]   term;
  logic [RESULT_W-1:0]   acc_next;
  logic [DATA_W-1:0]     rb_shift;
  logic                  last_step;

  mult_pp_radix4 #(
    .DATA_W (DATA_W)
  ) u_pp (
    .a   (a_q),
    .sel (rb_q[1:0]),
    .pp  (pp)
  );

  // Digit weight is 4^cnt, i.e. a left shift by 2*cnt.
  assign term     = {{(RESULT_W - DATA_W - 2){1'b0}}, pp} << {cnt_q, 1'b0};
  assign acc_next = acc_q + term;
  assign rb_shift = rb_q >> 2;

`ifdef MULT_SEQ_EARLY_EXIT_EN
  assign last_step = (cnt_q == LAST_CNT) || (rb_shift == '0);
`else
  assign last_step = (cnt_q == LAST_CNT);
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    rb_d     = rb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          a_d     = iDato_A;
          rb_d    = iDato_B;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = acc_next;
        rb_d  = rb_shift;
        cnt_d = cnt_q + 1'b1;
        if (last_step) begin
          result_d = acc_next;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      rb_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      rb_q     <= rb_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign oBusy   = (state_q == ST_RUN);
  assign oDone   = done_q;
  assign oResult = result_q;

endmodule

// File: tb/tb_mult_seq_radix4.sv
// Self-checking bench for mult_seq_radix4: vector table, handshake/reset corner cases, random ops.
module tb_mult_seq_radix4;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned STEPS  = DATA_W / 2;

  logic                Clock = 1'b0;
  logic                Reset;
  logic                iStart;
  logic [DATA_W-1:0]   iDato_A;
  logic [DATA_W-1:0]   iDato_B;
  logic                oBusy;
  logic                oDone;
  logic [2*DATA_W-1:0] oResult;

  int errors = 0;
  int checks = 0;

  mult_seq_radix4 #(
    .DATA_W (DATA_W)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .iStart  (iStart),
    .iDato_A (iDato_A),
    .iDato_B (iDato_B),
    .oBusy   (oBusy),
    .oDone   (oDone),
    .oResult (oResult)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
    logic [2*DATA_W-1:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Number of RUN edges the operation should take, from the multiplier value alone.
  function automatic int exp_lat(input logic [DATA_W-1:0] b);
`ifdef MULT_SEQ_EARLY_EXIT_EN
    int msb = -1;
    for (int i = 0; i < DATA_W; i++) if (b[i]) msb = i;
    if (msb < 0) return 1;
    return (msb + 2) / 2;
`else
    return STEPS;
`endif
  endfunction

  // Called #1 after an edge; presents a start for the next edge, then scrambles operands.
  task automatic start_op(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input bit hold);
    iDato_A = a;
    iDato_B = b;
    iStart  = 1'b1;
    @(posedge Clock);
    #1;
    if (hold) begin
      iDato_A = 16'd2;
      iDato_B = 16'd2;
    end else begin
      iStart  = 1'b0;
      iDato_A = DATA_W'($urandom);
      iDato_B = DATA_W'($urandom);
    end
  endtask

  // Called #1 after the start edge; waits for oDone and checks result, latency and handshake.
  task automatic wait_done(input logic [2*DATA_W-1:0] exp_res, input int exp_l, input string name);
    int lat = 0;
    int busy_cnt = 0;
    bit seen = 1'b0;
    bit stable = 1'b1;
    logic [2*DATA_W-1:0] prev;
    prev = oResult;
    if (oBusy) busy_cnt++;
    while (!seen && lat < 40) begin
      @(posedge Clock);
      #1;
      lat++;
      if (oDone) seen = 1'b1;
      else begin
        if (oBusy) busy_cnt++;
        if (oResult !== prev) stable = 1'b0;
      end
    end
    check({name, " done_seen"}, 64'(seen), 64'd1);
    check({name, " latency"}, 64'(lat), 64'(exp_l));
    check({name, " busy_cycles"}, 64'(busy_cnt), 64'(exp_l));
    check({name, " result"}, 64'(oResult), 64'(exp_res));
    check({name, " result_stable"}, 64'(stable), 64'd1);
    @(posedge Clock);
    #1;
    check({name, " done_pulse"}, 64'(oDone), 64'd0);
    check({name, " result_held"}, 64'(oResult), 64'(exp_res));
  endtask

  initial begin
    vec_t vecs[7];
    bit   done_after_reset;
    vecs[0] = '{16'd3,    16'd5,    32'd15};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    vecs[2] = '{16'h1234, 16'h0000, 32'd0};
    vecs[3] = '{16'd1000, 16'd3,    32'd3000};
    vecs[4] = '{16'd1,    16'hFFFF, 32'h0000FFFF};
    vecs[5] = '{16'hFFFF, 16'd1,    32'h0000FFFF};
    vecs[6] = '{16'h8000, 16'h4000, 32'h20000000};

    Reset   = 1'b0;
    iStart  = 1'b0;
    iDato_A = '0;
    iDato_B = '0;
    repeat (2) @(posedge Clock);
    #1;
    check("reset busy", 64'(oBusy), 64'd0);
    check("reset done", 64'(oDone), 64'd0);
    check("reset result", 64'(oResult), 64'd0);
    Reset = 1'b1;
    @(posedge Clock);
    #1;

    for (int i = 0; i < 7; i++) begin
      start_op(vecs[i].a, vecs[i].b, 1'b0);
      wait_done(vecs[i].exp, exp_lat(vecs[i].b), $sformatf("vec%0d", i));
    end

    // Start held high through RUN/DONE: the second op is taken only in the IDLE cycle after DONE.
    start_op(16'd7, 16'd9, 1'b1);
    begin
      int lat = 0;
      while (!oDone && lat < 40) begin
        @(posedge Clock);
        #1;
        lat++;
      end
      check("hold first latency", 64'(lat), 64'(exp_lat(16'd9)));
      check("hold first result", 64'(oResult), 64'd63);
    end
    @(posedge Clock);
    #1;
    check("hold idle busy", 64'(oBusy), 64'd0);
    check("hold idle done", 64'(oDone), 64'd0);
    @(posedge Clock);
    #1;
    iStart = 1'b0;
    check("hold second accepted", 64'(oBusy), 64'd1);
    wait_done(32'd4, exp_lat(16'd2), "hold second");

    // Reset during RUN clears everything at once and no done follows.
    start_op(16'd100, 16'd200, 1'b0);
    repeat (3) @(posedge Clock);
    #1;
    Reset = 1'b0;
    #1;
    check("midreset busy", 64'(oBusy), 64'd0);
    check("midreset done", 64'(oDone), 64'd0);
    check("midreset result", 64'(oResult), 64'd0);
    @(negedge Clock);
    Reset = 1'b1;
    done_after_reset = 1'b0;
    repeat (12) begin
      @(posedge Clock);
      #1;
      if (oDone || oBusy) done_after_reset = 1'b1;
    end
    check("midreset no_done", 64'(done_after_reset), 64'd0);
    check("midreset result_zero", 64'(oResult), 64'd0);

    // Random back-to-back operations against plain multiplication.
    for (int n = 0; n < 1000; n++) begin
      logic [DATA_W-1:0] ra, rb;
      ra = DATA_W'($urandom);
      case (n % 4)
        0: rb = DATA_W'($urandom);
        1: rb = DATA_W'($urandom_range(0, 15));
        2: rb = DATA_W'($urandom_range(0, 255));
        default: rb = DATA_W'($urandom);
      endcase
      start_op(ra, rb, 1'b0);
      wait_done((2*DATA_W)'(ra) * (2*DATA_W)'(rb), exp_lat(rb), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
